attendance_marker: RTL and testbench
====================================

ATTENDANCE_MARKER -- requirements
Module: attendance_marker

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low; clock port clk, reset port clr_n.
REQ-002 Parameter WINDOW, default 8, SHALL set lecture window length in clk cycles (legal 2..63).
REQ-003 Parameter LATE, default 4, SHALL set the window cycle from which a scan counts as late (legal 1..WINDOW-1).
REQ-004 Parameter MAX_LECT, default 25, SHALL set lectures per session (legal 1..31).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 clr_n  input  1  asynchronous active-low reset.
REQ-007 start_lecture  input  1  single-cycle pulse opening a lecture window.
REQ-008 scan  input  1  single-cycle pulse, student presence scan.
REQ-009 rec_ready  input  1  downstream attendance register accepts the record.
REQ-010 rec_valid  output  1  lecture record available.
REQ-011 rec_present  output  1  student attended the lecture.
REQ-012 rec_late  output  1  attendance was late.
REQ-013 rec_index  output  5  lecture number of the record, 1-based.
REQ-014 present_count  output  5  records sent with rec_present=1.
REQ-015 late_count  output  5  records sent with rec_late=1.
REQ-016 busy  output  1  high in OPEN or SEND.
REQ-017 session_done  output  1  high in DONE.
REQ-018 err_overlap  output  1  sticky: start_lecture seen outside IDLE.

Function
REQ-019 FSM states SHALL be IDLE, OPEN, SEND, DONE, all outputs registered.
REQ-020 IDLE: start_lecture SHALL move to OPEN next cycle with timer=0, present=0, late=0.
REQ-021 OPEN: timer SHALL increment by 1 each cycle, starting at 0 in the first OPEN cycle.
REQ-022 OPEN: first scan with timer<LATE SHALL set present=1, late=0.
REQ-023 OPEN: first scan with LATE<=timer<=WINDOW-1 SHALL set present=1, late=1.
REQ-024 Scans after the first in a window SHALL be ignored (first scan wins).
REQ-025 In the OPEN cycle with timer=WINDOW-1 (scan still sampled), state SHALL go to SEND and rec_valid SHALL assert the next cycle.
REQ-026 SEND: rec_valid, rec_present, rec_late, rec_index SHALL stay stable until the cycle rec_valid&rec_ready is high.
REQ-027 On handshake: rec_valid SHALL drop next cycle; present_count/late_count SHALL increment per the record; rec_index SHALL increment.
REQ-028 On handshake with rec_index=MAX_LECT, state SHALL go to DONE, else IDLE.
REQ-029 DONE SHALL hold until reset; start_lecture and scan ignored.
REQ-030 scan outside OPEN SHALL be ignored.
REQ-031 start_lecture in OPEN, SEND or DONE SHALL be ignored and SHALL set err_overlap, cleared only by reset.
REQ-032 start_lecture and scan in the same IDLE cycle: scan SHALL be ignored.
REQ-033 Counters SHALL not wrap; MAX_LECT<=31 bounds them.
REQ-034 rec_ready while rec_valid=0 SHALL have no effect.
REQ-035 Latency start_lecture to rec_valid SHALL be WINDOW+1 cycles.

Reset
REQ-036 clr_n low SHALL immediately force IDLE, rec_valid=0, rec_present=0, rec_late=0, rec_index=1, present_count=0, late_count=0, busy=0, session_done=0, err_overlap=0, timer=0.
REQ-037 Reset mid-OPEN or mid-SEND SHALL discard the pending record without handshake.
REQ-038 First start_lecture is honoured on the first rising edge after clr_n deasserts.

Verification
REQ-039 Defaults, start at cycle 0, scan at timer=2, rec_ready=1 -> rec_valid at cycle 9, present=1, late=0, index=1, present_count=1.
REQ-040 scan at timer=4, second scan at timer=5 -> present=1, late=1, late_count=1.
REQ-041 no scan, rec_ready low 5 cycles -> rec_valid held with fields stable 5 cycles, present=0, counts unchanged after handshake.
REQ-042 start_lecture during OPEN -> err_overlap=1, window timing unaffected, err_overlap stays 1 until reset.
REQ-043 MAX_LECT=3, three lectures all handshaken -> session_done=1 after third handshake; further start_lecture ignored, err_overlap=1.
REQ-044 clr_n low during SEND with rec_valid=1 -> rec_valid=0 immediately, rec_index=1, counts=0.

Source files
------------

// File: rtl/attendance_marker_if.sv
`default_nettype none
// ============================================================================
// Module      : attendance_marker_if
// Description : Lecture-record handshake bundle between the attendance marker
//               (master) and the downstream attendance register (slave).
//               rec_valid   : lecture record available
//               rec_ready   : downstream accepts the record
//               rec_present : student attended the lecture
//               rec_late    : attendance was late
//               rec_index   : 1-based lecture number of the record
// Revision    : 1.0  initial release
// ============================================================================
interface attendance_marker_if;
    logic       rec_valid;
    logic       rec_ready;
    logic       rec_present;
    logic       rec_late;
    logic [4:0] rec_index;

    modport master (
        output rec_valid,
        output rec_present,
        output rec_late,
        output rec_index,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_present,
        input  rec_late,
        input  rec_index,
        output rec_ready
    );
endinterface
`default_nettype wire

// File: rtl/attendance_marker.sv
`default_nettype none
// ============================================================================
// Module      : attendance_marker
// Description : Opens a WINDOW-cycle lecture window on start_lecture, records
//               whether the first scan arrived on time or late, and hands the
//               lecture record downstream over a valid/ready handshake.
//               After MAX_LECT lectures the session is finished.
// Ports       : clk           rising-edge clock
//               clr_n         asynchronous active-low reset
//               start_lecture pulse opening a lecture window
//               scan          pulse, student presence scan
//               rec           record handshake (master side)
//               present_count records sent with rec_present=1
//               late_count    records sent with rec_late=1
//               busy          high while a window is open or a record pending
//               session_done  high once all lectures are delivered
//               err_overlap   sticky: start_lecture seen outside IDLE
// Revision    : 1.0  initial release
// ============================================================================
module attendance_marker #(
    parameter int WINDOW   = 8,
    parameter int LATE     = 4,
    parameter int MAX_LECT = 25
) (
    input  wire logic             clk,
    input  wire logic             clr_n,
    input  wire logic             start_lecture,
    input  wire logic             scan,
    attendance_marker_if.master   rec,
    output logic [4:0]            present_count,
    output logic [4:0]            late_count,
    output logic                  busy,
    output logic                  session_done,
    output logic                  err_overlap
);

    localparam logic [5:0] C_LAST = 6'(WINDOW - 1);
    localparam logic [5:0] C_LATE = 6'(LATE);
    localparam logic [4:0] C_MAX  = 5'(MAX_LECT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t     r_state;
    logic [5:0] r_timer;
    logic       r_valid;
    logic       r_present;
    logic       r_late;
    logic [4:0] r_index;

    assign rec.rec_valid   = r_valid;
    assign rec.rec_present = r_present;
    assign rec.rec_late    = r_late;
    assign rec.rec_index   = r_index;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state       <= ST_IDLE;
            r_timer       <= 6'd0;
            r_valid       <= 1'b0;
            r_present     <= 1'b0;
            r_late        <= 1'b0;
            r_index       <= 5'd1;
            present_count <= 5'd0;
            late_count    <= 5'd0;
            busy          <= 1'b0;
            session_done  <= 1'b0;
            err_overlap   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A scan coinciding with start_lecture is dropped: the
                    // window only begins sampling in the following cycle.
                    if (start_lecture) begin
                        r_state   <= ST_OPEN;
                        r_timer   <= 6'd0;
                        r_present <= 1'b0;
                        r_late    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                ST_OPEN: begin
                    if (start_lecture) begin
                        err_overlap <= 1'b1;
                    end
                    // First scan wins; the present flag blocks later scans.
                    if (scan && !r_present) begin
                        r_present <= 1'b1;
                        r_late    <= (r_timer >= C_LATE);
                    end
                    if (r_timer == C_LAST) begin
                        r_state <= ST_SEND;
                        r_valid <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 6'd1;
                    end
                end

                ST_SEND: begin
                    if (start_lecture) begin
                        err_overlap <= 1'b1;
                    end
                    if (r_valid && rec.rec_ready) begin
                        r_valid <= 1'b0;
                        busy    <= 1'b0;
                        r_timer <= 6'd0;
                        if (r_present) begin
                            present_count <= present_count + 5'd1;
                        end
                        if (r_late) begin
                            late_count <= late_count + 5'd1;
                        end
                        // The last lecture keeps its index so the 5-bit
                        // counter can never wrap past MAX_LECT.
                        if (r_index == C_MAX) begin
                            r_state      <= ST_DONE;
                            session_done <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_index <= r_index + 5'd1;
                        end
                    end
                end

                ST_DONE: begin
                    if (start_lecture) begin
                        err_overlap <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_attendance_marker.sv
`default_nettype none
// ============================================================================
// Module      : tb_attendance_marker
// Description : Directed self-checking bench. Two instances share stimulus:
//               dut_a uses default parameters, dut_b uses MAX_LECT=3 so the
//               session completes after the third lecture.
// Revision    : 1.0  initial release
// ============================================================================
module tb_attendance_marker;

    logic clk;
    logic clr_n;
    logic start_lecture;
    logic scan;
    logic rec_ready;

    logic [4:0] pc_a, lc_a, pc_b, lc_b;
    logic       busy_a, done_a, err_a;
    logic       busy_b, done_b, err_b;

    int n_assert;
    int n_fail;

    attendance_marker_if if_a ();
    attendance_marker_if if_b ();

    assign if_a.rec_ready = rec_ready;
    assign if_b.rec_ready = rec_ready;

    attendance_marker dut_a (
        .clk           (clk),
        .clr_n         (clr_n),
        .start_lecture (start_lecture),
        .scan          (scan),
        .rec           (if_a),
        .present_count (pc_a),
        .late_count    (lc_a),
        .busy          (busy_a),
        .session_done  (done_a),
        .err_overlap   (err_a)
    );

    attendance_marker #(.WINDOW(8), .LATE(4), .MAX_LECT(3)) dut_b (
        .clk           (clk),
        .clr_n         (clr_n),
        .start_lecture (start_lecture),
        .scan          (scan),
        .rec           (if_b),
        .present_count (pc_b),
        .late_count    (lc_b),
        .busy          (busy_b),
        .session_done  (done_b),
        .err_overlap   (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start_lecture, then walk the 8 window cycles (timer 0..7),
    // scanning at timer s1/s2 (-1 = none). After return rec_valid should
    // have just risen on dut_a.
    task automatic lecture(input int s1, input int s2, input bit ovl, input bit scan_at_start);
        start_lecture = 1'b1;
        scan          = scan_at_start;
        tick();
        start_lecture = 1'b0;
        scan          = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) chk("valid_before_latency", 32'(if_a.rec_valid), 32'd0);
            scan          = (k == s1) || (k == s2);
            start_lecture = ovl && (k == 3);
            tick();
        end
        scan          = 1'b0;
        start_lecture = 1'b0;
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        clr_n         = 1'b0;
        start_lecture = 1'b0;
        scan          = 1'b0;
        rec_ready     = 1'b1;

        tick();
        chk("rst_valid",   32'(if_a.rec_valid), 32'd0);
        chk("rst_index",   32'(if_a.rec_index), 32'd1);
        chk("rst_pcount",  32'(pc_a),           32'd0);
        chk("rst_lcount",  32'(lc_a),           32'd0);
        chk("rst_busy",    32'(busy_a),         32'd0);
        chk("rst_done",    32'(done_a),         32'd0);
        chk("rst_err",     32'(err_a),          32'd0);
        chk("rst_present", 32'(if_a.rec_present), 32'd0);
        clr_n = 1'b1;
        tick();

        // Lecture 1: on-time scan at timer=2.
        lecture(2, -1, 1'b0, 1'b0);
        chk("l1_valid",   32'(if_a.rec_valid),   32'd1);
        chk("l1_present", 32'(if_a.rec_present), 32'd1);
        chk("l1_late",    32'(if_a.rec_late),    32'd0);
        chk("l1_index",   32'(if_a.rec_index),   32'd1);
        chk("l1_busy",    32'(busy_a),           32'd1);
        tick();
        chk("l1_valid_drop", 32'(if_a.rec_valid), 32'd0);
        chk("l1_pcount",     32'(pc_a),           32'd1);
        chk("l1_lcount",     32'(lc_a),           32'd0);
        chk("l1_index_inc",  32'(if_a.rec_index), 32'd2);
        chk("l1_busy_idle",  32'(busy_a),         32'd0);

        // Lecture 2: late scan at timer=4, second scan at 5 ignored.
        lecture(4, 5, 1'b0, 1'b0);
        chk("l2_present", 32'(if_a.rec_present), 32'd1);
        chk("l2_late",    32'(if_a.rec_late),    32'd1);
        tick();
        chk("l2_pcount", 32'(pc_a),           32'd2);
        chk("l2_lcount", 32'(lc_a),           32'd1);
        chk("l2_index",  32'(if_a.rec_index), 32'd3);

        // Lecture 3: no scan, downstream stalls 5 cycles.
        rec_ready = 1'b0;
        lecture(-1, -1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("l3_hold_valid",   32'(if_a.rec_valid),   32'd1);
            chk("l3_hold_present", 32'(if_a.rec_present), 32'd0);
            chk("l3_hold_late",    32'(if_a.rec_late),    32'd0);
            chk("l3_hold_index",   32'(if_a.rec_index),   32'd3);
            tick();
        end
        chk("l3_pcount_stall", 32'(pc_a), 32'd2);
        rec_ready = 1'b1;
        tick();
        chk("l3_valid_drop", 32'(if_a.rec_valid), 32'd0);
        chk("l3_pcount",     32'(pc_a),           32'd2);
        chk("l3_lcount",     32'(lc_a),           32'd1);
        chk("l3_index",      32'(if_a.rec_index), 32'd4);
        chk("b_done",        32'(done_b),         32'd1);
        chk("b_busy",        32'(busy_b),         32'd0);
        chk("b_pcount",      32'(pc_b),           32'd2);
        chk("b_err_pre",     32'(err_b),          32'd0);
        chk("a_done_not",    32'(done_a),         32'd0);

        // Scan while IDLE is ignored.
        scan = 1'b1;
        tick();
        scan = 1'b0;
        chk("idle_scan_busy", 32'(busy_a), 32'd0);

        // Lecture 4: overlapping start mid-window, on-time scan at timer=0.
        chk("l4_err_pre", 32'(err_a), 32'd0);
        lecture(0, -1, 1'b1, 1'b0);
        chk("l4_valid_timing", 32'(if_a.rec_valid),   32'd1);
        chk("l4_present",      32'(if_a.rec_present), 32'd1);
        chk("l4_late",         32'(if_a.rec_late),    32'd0);
        chk("l4_err",          32'(err_a),            32'd1);
        chk("b_err_done",      32'(err_b),            32'd1);
        chk("b_done_hold",     32'(done_b),           32'd1);
        chk("b_no_valid",      32'(if_b.rec_valid),   32'd0);
        tick();
        chk("l4_pcount",   32'(pc_a),  32'd3);
        chk("l4_err_held", 32'(err_a), 32'd1);

        // Lecture 5: scan together with start_lecture is dropped.
        lecture(-1, -1, 1'b0, 1'b1);
        chk("l5_present", 32'(if_a.rec_present), 32'd0);
        tick();
        chk("l5_pcount", 32'(pc_a),           32'd3);
        chk("l5_index",  32'(if_a.rec_index), 32'd6);
        chk("l5_err",    32'(err_a),          32'd1);

        // Lecture 6: reset while the record is pending.
        rec_ready = 1'b0;
        lecture(1, -1, 1'b0, 1'b0);
        chk("l6_valid", 32'(if_a.rec_valid), 32'd1);
        clr_n = 1'b0;
        #1;
        chk("rst_send_valid",  32'(if_a.rec_valid), 32'd0);
        chk("rst_send_index",  32'(if_a.rec_index), 32'd1);
        chk("rst_send_pcount", 32'(pc_a),           32'd0);
        chk("rst_send_lcount", 32'(lc_a),           32'd0);
        chk("rst_send_err",    32'(err_a),          32'd0);
        chk("rst_send_b_done", 32'(done_b),         32'd0);
        clr_n         = 1'b1;
        start_lecture = 1'b1;
        tick();
        start_lecture = 1'b0;
        chk("post_rst_start", 32'(busy_a), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
